// File: rtl/spi_slave.sv
// SPI mode-0 slave: 8-bit MSB-first frames on sclk/mosi/miso, synchronized into clk, with a host byte interface.
// Latency: pin edge to internal edge detect is SYNC_STAGES+1 clk; rx_valid / miso update 1 clk after a detected edge.
// Backpressure: none on the serial side; a full receive side drops the new byte and sets sticky overrun.
// Optional build macro SPI_SLAVE_RX_FIFO_EN replaces the single receive register with a FIFO_DEPTH-entry FIFO.
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       overrun
);

  // Reject unsupported parameterisations at elaboration time.
  if (SYNC_STAGES < 2 || FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("spi_slave: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of two");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_prev;
  logic                   ss_prev;

  logic sclk_s;
  logic mosi_s;
  logic ss_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;

  // Shift the pins through SYNC_STAGES flops; keep one more copy of the last stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      ss_prev   <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign ss_rise   = ss_s & ~ss_prev;

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   frame_start;
  logic   frame_end;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: select opens a frame, deselect closes it (partial byte is abandoned).
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit engine
  // ---------------------------------------------------------------------------
  // Only the first seven bits are held here; the eighth goes straight to the receive side.
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;

  logic       shift_en;
  logic       rx_edge;
  logic       tx_edge;
  logic       boundary;
  logic       tx_load;
  logic       tx_accept;
  logic       rx_push;
  logic [7:0] push_byte;

  assign shift_en  = (state_q == ACTIVE) && !ss_rise;
  assign rx_edge   = shift_en & sclk_rise;
  // The fall that follows a byte boundary must not shift: the freshly loaded
  // bit 7 of the next byte has to stay on miso until the next rising edge.
  assign tx_edge   = shift_en & sclk_fall & (bit_cnt != 3'd0);
  assign boundary  = rx_edge & (bit_cnt == 3'd7);
  assign tx_load   = frame_start | boundary;
  assign tx_accept = tx_wr & ~tx_full;
  assign rx_push   = boundary;
  assign push_byte = {rx_shift, mosi_s};

  // Receive shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (frame_start || frame_end) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (rx_edge) begin
      rx_shift <= push_byte[6:0];
      bit_cnt  <= bit_cnt + 3'd1;
    end
  end

  // Transmit shift register: load at frame start / byte boundary, shift on falling sclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_shift <= tx_full ? tx_hold : 8'h00;
    end else if (tx_edge) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // Holding register: a write lands only when empty; a load empties it.
  // A write on a load cycle with holding empty wins, so the byte waits for the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else if (tx_accept) begin
      tx_hold <= tx_data;
      tx_full <= 1'b1;
    end else if (tx_load) begin
      tx_full <= 1'b0;
    end
  end

  assign miso    = tx_shift[7];
  assign miso_oe = ~ss_s;

  // ---------------------------------------------------------------------------
  // Receive side
  // ---------------------------------------------------------------------------
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

  assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
  assign pop       = rx_rd & (count != '0);
  // A full FIFO still accepts a push when the head is being popped in the same cycle.
  assign push_ok   = rx_push & (~fifo_full | pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  // Pointers and occupancy, wrapping modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end

  // Sticky overrun when a completed byte could not be stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (rx_push && !push_ok) begin
      overrun <= 1'b1;
    end
  end

  assign rx_valid = (count != '0);
  // Gate the head so rx_data reads 0 whenever nothing is queued (including after reset).
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
`else
  // Single receive register: a push is accepted when empty or when the old byte is read in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (rx_push && (!rx_valid || rx_rd)) begin
      rx_data  <= push_byte;
      rx_valid <= 1'b1;
    end else if (rx_rd) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky overrun when a byte arrives on top of an unread one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (rx_push && rx_valid && !rx_rd) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as a mode-0 SPI master plus host, checks each scenario inline.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  logic       bnd_wr_en  = 1'b0;
  logic       bnd_rd_en  = 1'b0;
  logic [7:0] bnd_wr_dat = 8'h00;
  logic [7:0] mi;

  spi_slave #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ss_n    (ss_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_full (tx_full),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_rd   (rx_rd),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Mode-0 master: drive mosi while sclk is low, sample miso just before raising sclk.
  // On the 8th bit, optionally pulse tx_wr / rx_rd on the slave's boundary cycle.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      got = {got[6:0], miso};
      sclk = 1'b1;
      if (i == 7 && (bnd_wr_en || bnd_rd_en)) begin
        repeat (SYNC) @(negedge clk);
        tx_wr   = bnd_wr_en;
        tx_data = bnd_wr_dat;
        rx_rd   = bnd_rd_en;
        @(negedge clk);
        tx_wr = 1'b0;
        rx_rd = 1'b0;
        repeat (HALF - SYNC - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic select(input logic v);
    ss_n = v;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b expected 0", miso); end
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
    tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    tx_data = 8'hA5; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL basic_tx_full_set: got %b expected 1", tx_full); end
    select(1'b0);
    tests++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL basic_miso_oe: got %b expected 1", miso_oe); end
    spi_bits(8'h3C, 8, mi);
    tests++; if (mi !== 8'hA5) begin fails++; $display("FAIL basic_miso_byte: got %h expected a5", mi); end
    tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL basic_rx_data: got %h expected 3c", rx_data); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL basic_rx_valid: got %b expected 1", rx_valid); end
    repeat (5) @(negedge clk);
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL basic_rx_valid_held: got %b expected 1", rx_valid); end
    tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL basic_tx_full_clear: got %b expected 0", tx_full); end
    pop_rx();
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_rx_rd_clear: got %b expected 0", rx_valid); end
    select(1'b1);
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL basic_miso_oe_off: got %b expected 0", miso_oe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    select(1'b0);
    spi_bits(8'h01, 8, mi);
    spi_bits(8'h02, 8, mi);
    spi_bits(8'h03, 8, mi);
    select(1'b1);
`ifdef SPI_SLAVE_RX_FIFO_EN
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_fifo_overrun: got %b expected 0", overrun); end
    for (int k = 1; k <= 3; k++) begin
      exp_b = 8'(k);
      tests++; if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
        fails++; $display("FAIL b2b_fifo_entry%0d: got valid %b data %h expected valid 1 data %h", k, rx_valid, rx_data, exp_b);
      end
      pop_rx();
    end
`else
    exp_b = 8'h01;
    tests++; if (rx_data !== exp_b) begin fails++; $display("FAIL b2b_rx_data: got %h expected %h", rx_data, exp_b); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
    pop_rx();
`endif
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b expected 0", rx_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun_rst: got %b expected 0", overrun); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_empty_tx();
    select(1'b0);
    bnd_wr_en = 1'b1; bnd_wr_dat = 8'h5A;
    spi_bits(8'hC3, 8, mi);
    bnd_wr_en = 1'b0;
    tests++; if (mi !== 8'h00) begin fails++; $display("FAIL empty_first_byte: got %h expected 00", mi); end
    tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL empty_bnd_wr_full: got %b expected 1", tx_full); end
    tests++; if (rx_data !== 8'hC3) begin fails++; $display("FAIL empty_rx_data: got %h expected c3", rx_data); end
    pop_rx();
    spi_bits(8'h00, 8, mi);
    tests++; if (mi !== 8'h00) begin fails++; $display("FAIL empty_second_byte: got %h expected 00", mi); end
    tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL empty_hold_consumed: got %b expected 0", tx_full); end
    pop_rx();
    spi_bits(8'h00, 8, mi);
    tests++; if (mi !== 8'h5A) begin fails++; $display("FAIL empty_third_byte: got %h expected 5a", mi); end
    pop_rx();
    select(1'b1);
  endtask

  task automatic test_abort();
    select(1'b0);
    spi_bits(8'hFF, 5, mi);
    select(1'b1);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL abort_no_valid: got %b expected 0", rx_valid); end
    select(1'b0);
    spi_bits(8'hF0, 8, mi);
    tests++; if (rx_valid !== 1'b1 || rx_data !== 8'hF0) begin
      fails++; $display("FAIL abort_next_frame: got valid %b data %h expected valid 1 data f0", rx_valid, rx_data);
    end
    pop_rx();
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL abort_single_byte: got %b expected 0", rx_valid); end
    select(1'b1);
  endtask

  task automatic test_rd_push();
    select(1'b0);
    spi_bits(8'hAA, 8, mi);
    bnd_rd_en = 1'b1;
    spi_bits(8'h55, 8, mi);
    bnd_rd_en = 1'b0;
    tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL rdpush_rx_data: got %h expected 55", rx_data); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rdpush_overrun: got %b expected 0", overrun); end
    pop_rx();
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rdpush_one_entry: got %b expected 0", rx_valid); end
    select(1'b1);
  endtask

  task automatic test_rst_mid();
    select(1'b0);
    spi_bits(8'h11, 8, mi);
    tx_data = 8'h77; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    spi_bits(8'h0F, 4, mi);
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({miso, miso_oe, tx_full, rx_valid, overrun} !== 5'b0) begin
      fails++; $display("FAIL rstmid_flags: got miso %b oe %b full %b valid %b ovr %b expected all 0", miso, miso_oe, tx_full, rx_valid, overrun);
    end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8'h81, 8, mi);
    tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
      fails++; $display("FAIL rstmid_next_frame: got valid %b data %h expected valid 1 data 81", rx_valid, rx_data);
    end
    tests++; if (mi !== 8'h00) begin fails++; $display("FAIL rstmid_hold_cleared: got %h expected 00", mi); end
    pop_rx();
    select(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_empty_tx();
    test_abort();
    test_rd_push();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
